vector_xor_decrypter: RTL

VECTOR_XOR_DECRYPTER -- requirements
Module: vector_xor_decrypter

---
 rtl/vector_xor_decrypter_pkg.sv | 8 +
 rtl/vector_keystream_lfsr.sv | 16 +
 rtl/vector_xor.sv | 12 +
 rtl/vector_xor_decrypter.sv | 70 +++++++
 4 files changed

// File: rtl/vector_xor_decrypter_pkg.sv
// vector_xor_decrypter_pkg: shared widths, LFSR constants and FSM state type
package vector_xor_decrypter_pkg;
  localparam int N = 64;
  localparam int LEN_W = 16;
  localparam logic [N-1:0] LFSR_POLY = 64'hD800_0000_0000_0000;
  localparam logic [N-1:0] LFSR_ZERO_SUB = 64'h1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/vector_keystream_lfsr.sv
// vector_keystream_lfsr: 64-bit right-shifting Galois LFSR keystream (clk, rst, load+seed, step -> state)
module vector_keystream_lfsr
  import vector_xor_decrypter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] seed,
  output logic [N-1:0] state
);
  always_ff @(posedge clk)
    if (rst) state <= LFSR_ZERO_SUB;
    else if (load) state <= (seed == '0) ? LFSR_ZERO_SUB : seed;
    else if (step) state <= {1'b0, state[N-1:1]} ^ (state[0] ? LFSR_POLY : '0);
endmodule

// File: rtl/vector_xor.sv
// vector_xor: lane-wise byte XOR of two vectors (a, b -> y)
module vector_xor #(
  parameter int LANES = 8
) (
  input  logic [8*LANES-1:0] a,
  input  logic [8*LANES-1:0] b,
  output logic [8*LANES-1:0] y
);
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign y[8*g +: 8] = a[8*g +: 8] ^ b[8*g +: 8];
  end
endmodule

// File: rtl/vector_xor_decrypter.sv
// vector_xor_decrypter: framed LFSR-XOR stream decrypter; start/seed/frame_len begin a frame, in_*/out_* are valid/ready streams, busy/done report progress
module vector_xor_decrypter
  import vector_xor_decrypter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     seed,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  state_t state;
  logic [LEN_W-1:0] count, len;
  logic [N-1:0] ks, plain;
  logic accept, xfer, last;
  assign accept = (state == IDLE) && start;
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign xfer = in_valid && in_ready;
  assign last = count == len - 1'b1;
  assign busy = state != IDLE;
  // an empty frame must not disturb the keystream, so only real frames load it
  vector_keystream_lfsr u_lfsr (
    .clk(clk), .rst(rst), .load(accept && frame_len != '0), .step(xfer), .seed(seed), .state(ks)
  );
  vector_xor #(.LANES(N / 8)) u_xor (.a(in_data), .b(ks), .y(plain));
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      done <= 1'b0;
      count <= '0;
      len <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (frame_len == '0) done <= 1'b1;
        else begin
          state <= RUN;
          count <= '0;
          len <= frame_len;
        end
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        if (state == DRAIN && out_last) begin
          out_last <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
      end
      // a new word overrides the drain of the old one, giving back-to-back throughput
      if (xfer) begin
        out_valid <= 1'b1;
        out_data <= plain;
        out_last <= last;
        count <= count + 1'b1;
        if (last) state <= DRAIN;
      end
    end
endmodule
